// File: rtl/data_sram_responder.sv
// Data-side SRAM-like bus responder with a word array and byte-lane writes.
// Accepts loads/stores and answers in order after a fixed latency.
module data_sram_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    input  logic        addr_stall
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [2:0] CD_INIT = 3'(LATENCY - 1);

    logic [31:0] mem [DEPTH];

    logic                  q_wr   [2];
    logic [31:0]           q_word [2];
    logic [2:0]            q_cd   [2];
    logic [1:0]            count;

    logic [ADDR_WIDTH-1:0] idx;
    logic [31:0]           rd_word;
    logic [3:0]            be;
    logic                  accept;
    logic                  pop;
    logic                  push_slot;
    logic [2:0]            cd0_dec;
    logic [2:0]            cd1_dec;
    logic                  unused_addr_bits;

    assign idx              = data_addr[ADDR_WIDTH+1:2];
    assign unused_addr_bits = ^data_addr[31:ADDR_WIDTH+2];
    assign rd_word          = mem[idx];

    assign data_addr_ok = !rst && !addr_stall && (count < 2'd2);
    assign accept       = data_req && data_addr_ok;
    assign pop          = (count != 2'd0) && (q_cd[0] == 3'd0);

    // Countdowns saturate at zero.
    assign cd0_dec = (q_cd[0] != 3'd0) ? q_cd[0] - 3'd1 : 3'd0;
    assign cd1_dec = (q_cd[1] != 3'd0) ? q_cd[1] - 3'd1 : 3'd0;

    // New entry lands behind whatever survives this edge.
    assign push_slot = (count == 2'd1) && !pop;

    // Byte-lane enables; misaligned or reserved sizes write nothing.
    always_comb begin
        be = 4'b0000;
        unique case (data_size)
            2'd0: be = 4'b0001 << data_addr[1:0];
            2'd1: begin
                if (!data_addr[0])
                    be = 4'b0011 << {data_addr[1], 1'b0};
            end
            2'd2: begin
                if (data_addr[1:0] == 2'b00)
                    be = 4'b1111;
            end
            default: be = 4'b0000;
        endcase
    end

    // Store path: write enabled lanes on acceptance.
    always_ff @(posedge clk) begin
        if (accept && data_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b])
                    mem[idx][8*b +: 8] <= data_wdata[8*b +: 8];
            end
        end
    end

    // Pending queue: pop the ripe head, age entries, push the new one.
    always_ff @(posedge clk) begin
        if (rst) begin
            count        <= 2'd0;
            data_data_ok <= 1'b0;
            data_rdata   <= 32'd0;
            for (int i = 0; i < 2; i++) begin
                q_wr[i]   <= 1'b0;
                q_word[i] <= 32'd0;
                q_cd[i]   <= 3'd0;
            end
        end else begin
            data_data_ok <= pop;
            data_rdata   <= (pop && !q_wr[0]) ? q_word[0] : 32'd0;
            if (pop) begin
                q_wr[0]   <= q_wr[1];
                q_word[0] <= q_word[1];
                q_cd[0]   <= cd1_dec;
            end else begin
                q_cd[0] <= cd0_dec;
            end
            q_cd[1] <= cd1_dec;
            if (accept) begin
                q_wr[push_slot]   <= data_wr;
                q_word[push_slot] <= rd_word;
                q_cd[push_slot]   <= CD_INIT;
            end
            count <= count + 2'(accept) - 2'(pop);
        end
    end

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: two instances (latency 1 and 3) driven
// in lockstep and compared against a response-schedule reference model.
module tb_data_sram_responder;

    logic        clk;
    logic        rst;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] rd0;
    logic [31:0] rd1;
    logic [1:0]  aok;
    logic [1:0]  dok;

    int total = 0;
    int bad   = 0;

    data_sram_responder #(.ADDR_WIDTH(10), .LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst), .data_req(req), .data_wr(wr),
        .data_size(size), .data_addr(addr), .data_wdata(wdata),
        .data_rdata(rd0), .data_addr_ok(aok[0]),
        .data_data_ok(dok[0]), .addr_stall(stall)
    );

    data_sram_responder #(.ADDR_WIDTH(10), .LATENCY(3)) u_l3 (
        .clk(clk), .rst(rst), .data_req(req), .data_wr(wr),
        .data_size(size), .data_addr(addr), .data_wdata(wdata),
        .data_rdata(rd1), .data_addr_ok(aok[1]),
        .data_data_ok(dok[1]), .addr_stall(stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: memory with known-byte flags, and a table of responses
    // keyed by the edge at which each one is due.
    int          lat [2] = '{1, 3};
    string       nm  [2] = '{"l1", "l3"};
    logic [31:0] mm  [2][1024];
    logic [3:0]  mk  [2][1024];
    bit          sv  [2][16];
    logic [31:0] sval[2][16];
    logic [3:0]  sk  [2][16];
    int          outst[2];
    logic        exp_dok[2];
    logic [31:0] exp_rd [2];
    logic [3:0]  exp_k  [2];
    logic [31:0] last_rd[2];
    int          m;
    bit          primed;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] kmask(input logic [3:0] k);
        return {{8{k[3]}}, {8{k[2]}}, {8{k[1]}}, {8{k[0]}}};
    endfunction

    task automatic model_store(input int i, input int wi,
                               input logic [1:0] s, input logic [31:0] a,
                               input logic [31:0] wd);
        bit ln [4];
        int off;
        for (int b = 0; b < 4; b++) ln[b] = 0;
        off = int'(a[1:0]);
        if (s == 2'd0) begin
            ln[off] = 1;
        end else if (s == 2'd1 && off % 2 == 0) begin
            ln[off] = 1;
            ln[off+1] = 1;
        end else if (s == 2'd2 && off == 0) begin
            for (int b = 0; b < 4; b++) ln[b] = 1;
        end
        for (int b = 0; b < 4; b++) begin
            if (ln[b]) begin
                mm[i][wi][8*b +: 8] = wd[8*b +: 8];
                mk[i][wi][b] = 1'b1;
            end
        end
    endtask

    task automatic model_edge(input int i, input logic r, input logic q,
                              input logic w, input logic [1:0] s,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic st);
        bit acc;
        int slot;
        int due;
        int wi;
        acc = !r && !st && (outst[i] < 2) && q;
        if (r) begin
            for (int k = 0; k < 16; k++) sv[i][k] = 0;
            outst[i]   = 0;
            exp_dok[i] = 1'b0;
            exp_rd[i]  = 32'd0;
            exp_k[i]   = 4'hF;
            return;
        end
        slot = m % 16;
        if (sv[i][slot]) begin
            exp_dok[i]  = 1'b1;
            exp_rd[i]   = sval[i][slot];
            exp_k[i]    = sk[i][slot];
            sv[i][slot] = 0;
            outst[i]--;
        end else begin
            exp_dok[i] = 1'b0;
            exp_rd[i]  = 32'd0;
            exp_k[i]   = 4'hF;
        end
        if (acc) begin
            wi  = int'(a >> 2) % 1024;
            due = (m + lat[i]) % 16;
            sv[i][due] = 1;
            if (w) begin
                sval[i][due] = 32'd0;
                sk[i][due]   = 4'hF;
                model_store(i, wi, s, a, wd);
            end else begin
                sval[i][due] = mm[i][wi];
                sk[i][due]   = mk[i][wi];
            end
            outst[i]++;
        end
    endtask

    task automatic step(input logic r, input logic q, input logic w,
                        input logic [1:0] s, input logic [31:0] a,
                        input logic [31:0] wd, input logic st);
        logic [31:0] got;
        logic [31:0] km;
        @(negedge clk);
        rst = r; req = q; wr = w; size = s;
        addr = a; wdata = wd; stall = st;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk({nm[i], "_aok"}, 32'(aok[i]),
                32'(!r && !st && outst[i] < 2));
            if (primed) begin
                got = (i == 0) ? rd0 : rd1;
                km  = kmask(exp_k[i]);
                chk({nm[i], "_dok"}, 32'(dok[i]), 32'(exp_dok[i]));
                chk({nm[i], "_rdata"}, got & km, exp_rd[i] & km);
                if (dok[i] === 1'b1) last_rd[i] = got;
            end
        end
        @(posedge clk);
        m++;
        for (int i = 0; i < 2; i++) model_edge(i, r, q, w, s, a, wd, st);
        if (r) primed = 1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 2'd0, 32'd0, 32'd0, 0);
    endtask

    task automatic op(input logic w, input logic [1:0] s,
                      input logic [31:0] a, input logic [31:0] wd);
        step(0, 1, w, s, a, wd, 0);
        idle(2);
    endtask

    task automatic chk_last(input string tag, input logic [31:0] exp);
        chk({tag, "_l1"}, last_rd[0], exp);
        chk({tag, "_l3"}, last_rd[1], exp);
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; wr = 1'b0; size = 2'd0;
        addr = 32'd0; wdata = 32'd0; stall = 1'b0;
        m = 0; primed = 0;
        for (int i = 0; i < 2; i++) begin
            outst[i] = 0; exp_dok[i] = 1'b0;
            exp_rd[i] = 32'd0; exp_k[i] = 4'hF; last_rd[i] = 32'd0;
            for (int k = 0; k < 16; k++) sv[i][k] = 0;
            for (int k = 0; k < 1024; k++) begin
                mm[i][k] = 32'd0; mk[i][k] = 4'h0;
            end
        end

        step(1, 0, 0, 2'd0, 32'd0, 32'd0, 0);
        step(1, 1, 1, 2'd2, 32'h100, 32'h1, 0);
        idle(2);

        // Store then load back-to-back
        step(0, 1, 1, 2'd2, 32'h100, 32'hDEADBEEF, 0);
        step(0, 1, 0, 2'd2, 32'h100, 32'd0, 0);
        idle(5);
        chk_last("raw", 32'hDEADBEEF);

        // Byte merge and misaligned halfword
        op(1, 2'd2, 32'h100, 32'h11223344);
        op(1, 2'd0, 32'h103, 32'hAAAAAAAA);
        op(0, 2'd2, 32'h100, 32'd0);
        idle(5);
        chk_last("sb", 32'hAA223344);
        op(1, 2'd1, 32'h101, 32'hFFFFFFFF);
        op(0, 2'd2, 32'h100, 32'd0);
        idle(5);
        chk_last("sh_mis", 32'hAA223344);

        // Held request stream exercises backpressure
        for (int k = 0; k < 6; k++)
            step(0, 1, 0, 2'd2, 32'h100, 32'd0, 0);
        idle(5);

        // Stall hook
        op(1, 2'd2, 32'h200, 32'h0BADF00D);
        for (int k = 0; k < 4; k++)
            step(0, 1, 0, 2'd2, 32'h200, 32'd0, 1);
        step(0, 1, 0, 2'd2, 32'h200, 32'd0, 0);
        idle(5);
        chk_last("stall", 32'h0BADF00D);

        // Reset with a load in flight; the earlier store survives
        op(1, 2'd2, 32'h200, 32'h12345678);
        idle(3);
        step(0, 1, 0, 2'd2, 32'h200, 32'd0, 0);
        last_rd[0] = 32'd0;
        last_rd[1] = 32'd0;
        step(1, 0, 0, 2'd0, 32'd0, 32'd0, 0);
        step(1, 0, 0, 2'd0, 32'd0, 32'd0, 0);
        idle(5);
        chk_last("flush", 32'd0);
        op(0, 2'd2, 32'h200, 32'd0);
        idle(5);
        chk_last("keep", 32'h12345678);

        // Address wrap
        op(1, 2'd2, 32'h1004, 32'h5);
        op(0, 2'd2, 32'h4, 32'd0);
        idle(5);
        chk_last("wrap", 32'h5);

        // Randomized traffic
        for (int k = 0; k < 2000; k++) begin
            step($urandom_range(0, 63) == 0,
                 $urandom_range(0, 3) != 0,
                 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)),
                 $urandom & 32'hFFFF_F03F,
                 $urandom,
                 $urandom_range(0, 3) == 0);
        end
        idle(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
